uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small first-word-fall-through FIFO.
// Sticky frame/overrun flags are cleared by clr_err; a new error in the same cycle takes priority.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int DIV   = 325,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_s1, rx_s2, rx_prev;
    logic [DW-1:0] div_cnt;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          push_pend;
    logic          tick, start_edge, frame_evt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, wr_ok;

    // Synchronizer plus one extra stage for falling-edge detection on the clean line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign start_edge = (state == IDLE) && !rx_s2 && rx_prev;
    assign tick       = (div_cnt == DIV_LAST);
    assign frame_evt  = (state == STOP) && tick && (tick_cnt == 4'd15) && !rx_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  div_cnt <= '0;
        else if (start_edge || tick) div_cnt <= '0;
        else                         div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= 4'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            push_pend <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            case (state)
                IDLE: if (start_edge) begin
                    state    <= START;
                    tick_cnt <= 4'd0;
                end
                START: if (tick) begin
                    if (tick_cnt == 4'd7) begin
                        tick_cnt <= 4'd0;
                        bit_idx  <= 3'd0;
                        state    <= rx_s2 ? IDLE : DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                DATA: if (tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_reg[bit_idx] <= rx_s2;
                        bit_idx            <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: if (tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        state     <= IDLE;
                        push_pend <= rx_s2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // shift_reg stays stable for the cycle after the stop sample, so it is pushed directly.
    assign pop   = rd_en && (count != '0);
    assign wr_ok = push_pend && ((count != FULL_CNT) || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)      count <= count + 1'b1;
            else if (!wr_ok && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= shift_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= (frame_err && !clr_err) || frame_evt;
            overrun   <= (overrun && !clr_err) || (push_pend && (count == FULL_CNT) && !pop);
        end
    end

    assign rx_valid = (count != '0);
    assign rx_full  = (count == FULL_CNT);
    assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at DIV=4 (64 clk per bit): directed cases followed by random frames,
// all checked against a queue-based model of the FIFO and sticky flags.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, rx, rd_en, clr_err;
    logic [7:0] rx_data;
    logic       rx_valid, rx_full, frame_err, overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    logic       m_ferr, m_ovr;
    logic       v_pre, v_post;

    uart_rx_fifo #(.DIV(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_full(rx_full),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, 32'(rx_valid), 32'(q.size() > 0));
        chk({tag, ".full"},  32'(rx_full),  32'(q.size() == DEPTH));
        chk({tag, ".data"},  32'(rx_data),  32'((q.size() > 0) ? q[0] : 8'h00));
        chk({tag, ".ferr"},  32'(frame_err), 32'(m_ferr));
        chk({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop_one(input string tag);
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_state(tag);
    endtask

    task automatic clear_flags();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One 640-clk frame; pop_at/clr_at/rst_at are cycle offsets from the start edge (-1 = unused).
    task automatic frame(input logic [7:0] b, input logic stop, input int pop_at,
                         input int clr_at, input int rst_at);
        logic [9:0] line;
        line = {stop, b, 1'b0};
        for (int i = 0; i < 640; i++) begin
            @(posedge clk); #1;
            if (i == 611) v_pre  = rx_valid;
            if (i == 612) v_post = rx_valid;
            rx      = line[i / 64];
            rd_en   = (i == pop_at);
            clr_err = (i == clr_at);
            reset   = !(rst_at >= 0 && i >= rst_at && i < rst_at + 5);
        end
        @(posedge clk); #1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        if (rst_at >= 0) begin
            q.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            if (clr_at >= 0) begin
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
            end
            if (!stop) m_ferr = 1'b1;
            else begin
                if (pop_at >= 0 && q.size() > 0) void'(q.pop_front());
                if (q.size() == DEPTH) m_ovr = 1'b1;
                else q.push_back(b);
            end
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         pa;
        rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0; reset = 1'b0;
        m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_state("reset");
        reset = 1'b1;
        idle(20);

        // Single good byte, with exact push timing
        frame(8'hA5, 1'b1, -1, -1, -1);
        chk("a5.pre_push", 32'(v_pre), 32'd0);
        chk("a5.post_push", 32'(v_post), 32'd1);
        check_state("a5");
        pop_one("a5.pop");

        // Short low glitch must be rejected
        @(posedge clk); #1 rx = 1'b0;
        repeat (20) @(posedge clk);
        idle(700);
        check_state("glitch");

        // Framing error followed by a break; a cleared flag must stay clear
        frame(8'h3C, 1'b0, -1, -1, -1);
        check_state("break.err");
        repeat (100) @(posedge clk);
        clear_flags();
        repeat (500) @(posedge clk);
        #1 check_state("break.once");
        idle(100);
        check_state("break.idle");

        // Clear and new framing error in the same cycle: flag ends set
        frame(8'h11, 1'b0, -1, 610, -1);
        idle(50);
        check_state("clr_vs_set");
        clear_flags();
        check_state("clr_vs_set.cleared");

        // Five bytes into a four-deep FIFO
        for (int k = 1; k <= 5; k++) begin
            frame(8'(k), 1'b1, -1, -1, -1);
            check_state($sformatf("fill%0d", k));
        end
        for (int k = 0; k < 4; k++) pop_one($sformatf("drain%0d", k));
        clear_flags();
        check_state("drain.clr");

        // Full FIFO with pop on the push cycle
        for (int k = 0; k < 4; k++) frame(8'h10 + 8'(k), 1'b1, -1, -1, -1);
        frame(8'h77, 1'b1, 611, -1, -1);
        check_state("pushpop");
        for (int k = 0; k < 4; k++) pop_one($sformatf("pushpop.drain%0d", k));

        // Reset in the middle of bit 4, then a clean frame
        frame(8'hF0, 1'b1, -1, -1, 340);
        idle(20);
        check_state("midreset");
        frame(8'h5A, 1'b1, -1, -1, -1);
        check_state("after_reset");
        pop_one("after_reset.pop");

        // Random traffic
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 2)) pop_one($sformatf("rnd%0d.pop", n));
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            pa = (rs && $urandom_range(0, 3) == 0) ? 611 : -1;
            frame(rb, rs, pa, -1, -1);
            idle(30);
            check_state($sformatf("rnd%0d", n));
            if ($urandom_range(0, 2) == 0) begin
                clear_flags();
                check_state($sformatf("rnd%0d.clr", n));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
